// File: rtl/data_sync_pkg.sv
// Shared constants and types for the data_sync multi-bit CDC receiver.
package data_sync_pkg;

  typedef int unsigned ds_depth_t;

  localparam ds_depth_t   DS_MIN_STAGES = 2;
  localparam ds_depth_t   DS_DEF_STAGES = 2;
  localparam int unsigned DS_DEF_WIDTH  = 8;

endpackage

// File: rtl/data_sync_sync_chain.sv
// Single-bit flop synchronizer chain; also usable on the source side for the ack toggle.
module data_sync_sync_chain
  import data_sync_pkg::*;
#(
  parameter ds_depth_t NUM_STAGES = DS_DEF_STAGES
) (
  input  logic CLK,
  input  logic Reset,
  input  logic d_i,
  output logic q_o
);

  if (NUM_STAGES < DS_MIN_STAGES) begin : g_bad_depth
    $error("data_sync_sync_chain: NUM_STAGES must be >= 2");
  end

  logic [NUM_STAGES-1:0] chain_q;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[NUM_STAGES-2:0], d_i};
    end
  end

  assign q_o = chain_q[NUM_STAGES-1];

endmodule

// File: rtl/data_sync.sv
// MCP-style bus receiver: synchronize bus_enable, detect its rise, capture the bus.
// Optional acknowledge toggle output is built when DATA_SYNC_ACK_EN is defined.
module data_sync
  import data_sync_pkg::*;
#(
  parameter ds_depth_t   NUM_STAGES = DS_DEF_STAGES,
  parameter int unsigned BUS_WIDTH  = DS_DEF_WIDTH
) (
  input  logic                 CLK,
  input  logic                 Reset,
  input  logic [BUS_WIDTH-1:0] unsync_bus,
  input  logic                 bus_enable,
  output logic [BUS_WIDTH-1:0] sync_bus,
  output logic                 enable_pulse
`ifdef DATA_SYNC_ACK_EN
  ,
  output logic                 ack_toggle
`endif
);

  if (BUS_WIDTH < 1) begin : g_bad_width
    $error("data_sync: BUS_WIDTH must be >= 1");
  end

  logic                 en_sync;
  logic                 en_prev_q;
  logic                 pulse_c;
  logic                 pulse_q;
  logic [BUS_WIDTH-1:0] sync_bus_q;
  logic [BUS_WIDTH-1:0] sync_bus_d;

  data_sync_sync_chain #(
    .NUM_STAGES(NUM_STAGES)
  ) u_en_chain (
    .CLK  (CLK),
    .Reset(Reset),
    .d_i  (bus_enable),
    .q_o  (en_sync)
  );

  // en_prev resets low, so an enable already high at reset release still captures once.
  assign pulse_c    = en_sync & ~en_prev_q;
  assign sync_bus_d = pulse_c ? unsync_bus : sync_bus_q;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      en_prev_q  <= 1'b0;
      pulse_q    <= 1'b0;
      sync_bus_q <= '0;
    end else begin
      en_prev_q  <= en_sync;
      pulse_q    <= pulse_c;
      sync_bus_q <= sync_bus_d;
    end
  end

  assign sync_bus     = sync_bus_q;
  assign enable_pulse = pulse_q;

`ifdef DATA_SYNC_ACK_EN
  logic ack_q;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      ack_q <= 1'b0;
    end else if (pulse_c) begin
      ack_q <= ~ack_q;
    end
  end

  assign ack_toggle = ack_q;
`endif

endmodule

// File: tb/tb_data_sync.sv
// Bench for data_sync: default (2 stages, 8 bits) and wide (6 stages, 9 bits) instances.
module tb_data_sync;

  localparam int unsigned NA = 2;
  localparam int unsigned WA = 8;
  localparam int unsigned NB = 6;
  localparam int unsigned WB = 9;

  logic          clk    = 1'b0;
  logic          rst    = 1'b1;
  logic          be     = 1'b0;
  logic [WA-1:0] data_a = '0;
  logic [WB-1:0] data_b = '0;
  logic [WA-1:0] bus_a;
  logic [WB-1:0] bus_b;
  logic          pulse_a;
  logic          pulse_b;
  logic          ack_a;
  logic          ack_b;

  int checks = 0;
  int fails  = 0;

  // Entries are {ack, pulse, bus} expected after each clock edge.
  logic [WA+1:0] exp_a_q[$];
  logic [WB+1:0] exp_b_q[$];

  always #5 clk = ~clk;

  data_sync #(.NUM_STAGES(NA), .BUS_WIDTH(WA)) dut_a (
    .CLK         (clk),
    .Reset       (rst),
    .unsync_bus  (data_a),
    .bus_enable  (be),
    .sync_bus    (bus_a),
    .enable_pulse(pulse_a)
`ifdef DATA_SYNC_ACK_EN
    ,
    .ack_toggle  (ack_a)
`endif
  );

  data_sync #(.NUM_STAGES(NB), .BUS_WIDTH(WB)) dut_b (
    .CLK         (clk),
    .Reset       (rst),
    .unsync_bus  (data_b),
    .bus_enable  (be),
    .sync_bus    (bus_b),
    .enable_pulse(pulse_b)
`ifdef DATA_SYNC_ACK_EN
    ,
    .ack_toggle  (ack_b)
`endif
  );

`ifndef DATA_SYNC_ACK_EN
  assign ack_a = 1'b0;
  assign ack_b = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: enable_pulse after edge e is set when bus_enable was sampled
  // high at edge e-N and low at edge e-N-1; the bus then takes the value present at e.
  logic          hist_a[$];
  logic          hist_b[$];
  logic [WA-1:0] mbus_a;
  logic [WB-1:0] mbus_b;
  logic          mack_a;
  logic          mack_b;

  initial begin : model
    logic pa;
    logic pb;
    forever begin
      @(posedge clk);
      if (rst) begin
        hist_a = {};
        hist_b = {};
        for (int i = 0; i < NA + 2; i++) hist_a.push_back(1'b0);
        for (int i = 0; i < NB + 2; i++) hist_b.push_back(1'b0);
        mbus_a = '0;
        mbus_b = '0;
        mack_a = 1'b0;
        mack_b = 1'b0;
        pa     = 1'b0;
        pb     = 1'b0;
      end else begin
        hist_a.push_back(be);
        hist_b.push_back(be);
        void'(hist_a.pop_front());
        void'(hist_b.pop_front());
        pa = hist_a[1] & ~hist_a[0];
        pb = hist_b[1] & ~hist_b[0];
        if (pa) begin
          mbus_a = data_a;
          mack_a = ~mack_a;
        end
        if (pb) begin
          mbus_b = data_b;
          mack_b = ~mack_b;
        end
      end
      exp_a_q.push_back({mack_a, pa, mbus_a});
      exp_b_q.push_back({mack_b, pb, mbus_b});
    end
  end

  initial begin : monitor
    logic [WA+1:0] ea;
    logic [WB+1:0] eb;
    forever begin
      @(posedge clk);
      #1;
      if (exp_a_q.size() > 0) begin
        ea = exp_a_q.pop_front();
        chk("a_pulse", {31'd0, pulse_a}, {31'd0, ea[WA]});
        chk("a_bus", {24'd0, bus_a}, {24'd0, ea[WA-1:0]});
`ifdef DATA_SYNC_ACK_EN
        chk("a_ack", {31'd0, ack_a}, {31'd0, ea[WA+1]});
`endif
      end
      if (exp_b_q.size() > 0) begin
        eb = exp_b_q.pop_front();
        chk("b_pulse", {31'd0, pulse_b}, {31'd0, eb[WB]});
        chk("b_bus", {23'd0, bus_b}, {23'd0, eb[WB-1:0]});
`ifdef DATA_SYNC_ACK_EN
        chk("b_ack", {31'd0, ack_b}, {31'd0, eb[WB+1]});
`endif
      end
    end
  end

  task automatic drive(input logic r, input logic e, input logic [WA-1:0] da,
                       input logic [WB-1:0] db, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst    = r;
      be     = e;
      data_a = da;
      data_b = db;
    end
  endtask

  int pulses_a = 0;
  int pulses_b = 0;
  always @(posedge clk) begin
    if (pulse_a) pulses_a <= pulses_a + 1;
    if (pulse_b) pulses_b <= pulses_b + 1;
  end

  initial begin : stim
    logic [WA-1:0] ra;
    logic [WB-1:0] rb;
    int hi;
    int lo;
    int pa0;
    int pb0;

    // Reset held with enable high and data present.
    drive(1'b1, 1'b1, 8'hA5, 9'h0A5, 3);
    #2;
    chk("rst_bus_a", {24'd0, bus_a}, 32'd0);
    chk("rst_pulse_a", {31'd0, pulse_a}, 32'd0);
    chk("rst_ack_a", {31'd0, ack_a}, 32'd0);
    chk("rst_bus_b", {23'd0, bus_b}, 32'd0);
    drive(1'b0, 1'b1, 8'hA5, 9'h0A5, 8);
    drive(1'b0, 1'b0, 8'hA5, 9'h0A5, 8);

    drive(1'b0, 1'b1, 8'h3C, 9'h13C, 8);
    drive(1'b0, 1'b0, 8'h3C, 9'h13C, 8);

    // Long enable: exactly one pulse per instance.
    pa0 = pulses_a;
    pb0 = pulses_b;
    drive(1'b0, 1'b1, 8'h11, 9'h011, 20);
    drive(1'b0, 1'b0, 8'h11, 9'h011, 8);
    chk("long_pulses_a", pulses_a - pa0, 32'd1);
    chk("long_pulses_b", pulses_b - pb0, 32'd1);

    // Back-to-back with a short gap.
    drive(1'b0, 1'b1, 8'h01, 9'h001, 4);
    drive(1'b0, 1'b0, 8'h01, 9'h001, 3);
    drive(1'b0, 1'b1, 8'hFE, 9'h0FE, 4);
    drive(1'b0, 1'b0, 8'hFE, 9'h0FE, 8);

    // Reset one edge after enable rises, enable kept high through release.
    drive(1'b0, 1'b1, 8'h77, 9'h077, 1);
    drive(1'b1, 1'b1, 8'h77, 9'h077, 2);
    #2;
    chk("midrst_bus_a", {24'd0, bus_a}, 32'd0);
    chk("midrst_pulse_a", {31'd0, pulse_a}, 32'd0);
    drive(1'b0, 1'b1, 8'h77, 9'h077, 10);
    drive(1'b0, 1'b0, 8'h77, 9'h077, 8);

    // All-ones on the wide instance.
    drive(1'b0, 1'b1, 8'hFF, 9'h1FF, 8);
    drive(1'b0, 1'b0, 8'hFF, 9'h1FF, 8);

    for (int t = 0; t < 30; t++) begin
      ra = WA'($urandom);
      rb = WB'($urandom);
      hi = $urandom_range(1, 10);
      lo = $urandom_range(1, 10);
      drive(1'b0, 1'b1, ra, rb, hi);
      drive(1'b0, 1'b0, ra, rb, lo);
    end

    drive(1'b0, 1'b0, '0, '0, 10);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
